// File: rtl/inst_decode_queue.sv
// Decode-stage instruction queue: buffers fetched {pc, inst} pairs and presents
// up to ISSUE_WIDTH decoded head entries per cycle, keeping branch + delay slot together.
//
// Ports:
//   clk, resetn (sync, active low), flush
//   in_valid/in_count/in_pc/in_inst  -> push side, in_ready from registered occupancy
//   out_valid/out_pc/out_inst_d      -> head entries, contiguous valid from slot 0
//   out_accept                       -> entries consumed this cycle
//   q_count                          -> current occupancy

package idq_pkg;

    localparam logic [2:0] BR_NONE  = 3'd0;
    localparam logic [2:0] BR_BEQ   = 3'd1;
    localparam logic [2:0] BR_BNE   = 3'd2;
    localparam logic [2:0] BR_J     = 3'd3;
    localparam logic [2:0] BR_JAL   = 3'd4;
    localparam logic [2:0] BR_JR    = 3'd5;
    localparam logic [2:0] BR_JALR  = 3'd6;
    localparam logic [2:0] BR_OTHER = 3'd7;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        wr_en;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic [2:0]  br_op;
        logic        is_load;
        logic        is_store;
        logic        inst_invalid;
    } decoded_inst_t;

endpackage

// Single-instruction decoder (MIPS32 integer subset), purely combinational.
module idq_decoder
    import idq_pkg::*;
(
    input  logic [31:0]   inst,
    output decoded_inst_t dec
);

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [31:0] simm;
    logic [31:0] zimm;

    always_comb begin
        op   = inst[31:26];
        fn   = inst[5:0];
        simm = {{16{inst[15]}}, inst[15:0]};
        zimm = {16'b0, inst[15:0]};
        dec  = '0;
        dec.rs = inst[25:21];
        dec.rt = inst[20:16];
        case (op)
            6'h00: begin
                dec.rd    = inst[15:11];
                dec.wr_en = 1'b1;
                case (fn)
                    6'h00: begin dec.alu_op = ALU_SLL; dec.imm = {27'b0, inst[10:6]}; end
                    6'h02: begin dec.alu_op = ALU_SRL; dec.imm = {27'b0, inst[10:6]}; end
                    6'h03: begin dec.alu_op = ALU_SRA; dec.imm = {27'b0, inst[10:6]}; end
                    6'h08: begin dec.br_op = BR_JR; dec.wr_en = 1'b0; end
                    6'h09: dec.br_op  = BR_JALR;
                    6'h21: dec.alu_op = ALU_ADD;
                    6'h23: dec.alu_op = ALU_SUB;
                    6'h24: dec.alu_op = ALU_AND;
                    6'h25: dec.alu_op = ALU_OR;
                    6'h26: dec.alu_op = ALU_XOR;
                    6'h27: dec.alu_op = ALU_NOR;
                    6'h2a: dec.alu_op = ALU_SLT;
                    6'h2b: dec.alu_op = ALU_SLTU;
                    default: begin
                        dec.wr_en        = 1'b0;
                        dec.inst_invalid = 1'b1;
                    end
                endcase
            end
            6'h01: begin
                dec.imm = simm;
                if (inst[20:17] == 4'b0) dec.br_op = BR_OTHER;
                else dec.inst_invalid = 1'b1;
            end
            6'h02: begin dec.br_op = BR_J; dec.imm = {4'b0, inst[25:0], 2'b0}; end
            6'h03: begin
                dec.br_op = BR_JAL;
                dec.imm   = {4'b0, inst[25:0], 2'b0};
                dec.wr_en = 1'b1;
                dec.rd    = 5'd31;
            end
            6'h04: begin dec.br_op = BR_BEQ;   dec.imm = simm; end
            6'h05: begin dec.br_op = BR_BNE;   dec.imm = simm; end
            6'h06: begin dec.br_op = BR_OTHER; dec.imm = simm; end
            6'h07: begin dec.br_op = BR_OTHER; dec.imm = simm; end
            6'h09: begin dec.alu_op = ALU_ADD;  dec.imm = simm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0a: begin dec.alu_op = ALU_SLT;  dec.imm = simm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0b: begin dec.alu_op = ALU_SLTU; dec.imm = simm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0c: begin dec.alu_op = ALU_AND;  dec.imm = zimm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0d: begin dec.alu_op = ALU_OR;   dec.imm = zimm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0e: begin dec.alu_op = ALU_XOR;  dec.imm = zimm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h0f: begin
                dec.alu_op = ALU_LUI;
                dec.imm    = {inst[15:0], 16'b0};
                dec.wr_en  = 1'b1;
                dec.rd     = inst[20:16];
            end
            6'h23: begin dec.is_load = 1'b1; dec.imm = simm; dec.wr_en = 1'b1; dec.rd = inst[20:16]; end
            6'h2b: begin dec.is_store = 1'b1; dec.imm = simm; end
            default: dec.inst_invalid = 1'b1;
        endcase
    end

endmodule

module inst_decode_queue
    import idq_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int ISSUE_WIDTH = 2,
    parameter int DEPTH       = 8,
    parameter int PAIR_DSLOT  = 1,
    localparam int CW = $clog2(FETCH_WIDTH + 1),
    localparam int AW = $clog2(ISSUE_WIDTH + 1),
    localparam int QW = $clog2(DEPTH + 1)
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 flush,
    input  logic                                 in_valid,
    input  logic [CW-1:0]                        in_count,
    input  logic [FETCH_WIDTH-1:0][31:0]         in_pc,
    input  logic [FETCH_WIDTH-1:0][31:0]         in_inst,
    output logic                                 in_ready,
    output logic [ISSUE_WIDTH-1:0]               out_valid,
    output logic [ISSUE_WIDTH-1:0][31:0]         out_pc,
    output decoded_inst_t [ISSUE_WIDTH-1:0]      out_inst_d,
    input  logic [AW-1:0]                        out_accept,
    output logic [QW-1:0]                        q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [QW-1:0] READY_MAX = QW'(DEPTH - FETCH_WIDTH);
    localparam bit PAIR_EN = (PAIR_DSLOT != 0) && (ISSUE_WIDTH > 1);

    logic [31:0]   pc_q   [DEPTH];
    logic [31:0]   pc_d   [DEPTH];
    logic [31:0]   inst_q [DEPTH];
    logic [31:0]   inst_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [QW-1:0] count_q, count_d;

    logic                   push;
    logic [ISSUE_WIDTH-1:0] raw_valid;
    logic [ISSUE_WIDTH-1:0] last_slot;
    logic [ISSUE_WIDTH-1:0] is_br;
    logic [ISSUE_WIDTH-1:0][31:0] head_inst;
    logic [AW-1:0]          n_valid;

    assign in_ready = (count_q <= READY_MAX);
    assign push     = in_valid & in_ready & ~flush;
    assign q_count  = count_q;

    always_comb begin
        pc_d   = pc_q;
        inst_d = inst_q;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (push && (i < int'(in_count))) begin
                pc_d[wr_ptr_q + PW'(i)]   = in_pc[i];
                inst_d[wr_ptr_q + PW'(i)] = in_inst[i];
            end
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + PW'(out_accept);
        wr_ptr_d = wr_ptr_q + (push ? PW'(in_count) : '0);
        count_d  = count_q + (push ? QW'(in_count) : '0) - QW'(out_accept);
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; count alone qualifies which entries are live.
    always_ff @(posedge clk) begin
        pc_q   <= pc_d;
        inst_q <= inst_d;
    end

    always_comb begin
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            out_pc[i]    = pc_q[rd_ptr_q + PW'(i)];
            head_inst[i] = inst_q[rd_ptr_q + PW'(i)];
            raw_valid[i] = (QW'(i) < count_q);
        end
    end

    for (genvar g = 0; g < ISSUE_WIDTH; g++) begin : g_dec
        idq_decoder u_dec (
            .inst (head_inst[g]),
            .dec  (out_inst_d[g])
        );
        assign is_br[g] = (out_inst_d[g].br_op != BR_NONE);
    end

    // A branch in the last presented slot has its delay slot outside the
    // issue window, so hold it back until both can leave together.
    assign last_slot = raw_valid & ~(raw_valid >> 1);

    always_comb begin
        out_valid = raw_valid;
        if (PAIR_EN) out_valid = raw_valid & ~(last_slot & is_br);
        n_valid = '0;
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            n_valid = n_valid + AW'(out_valid[i]);
        end
    end

    accept_in_range: assert property (
        @(posedge clk) disable iff (!resetn || flush)
        out_accept <= n_valid
    );

endmodule

// File: tb/tb_inst_decode_queue.sv
// Directed testbench for inst_decode_queue (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).
// Each task drives one scenario and checks outputs against hand-computed values.
module tb_inst_decode_queue;
    import idq_pkg::*;

    localparam logic [31:0] I_ADDIU = 32'h24010001;
    localparam logic [31:0] I_ADDU  = 32'h00221821;
    localparam logic [31:0] I_BEQ   = 32'h10220004;
    localparam logic [31:0] I_NOP   = 32'h00000000;
    localparam logic [31:0] I_JR    = 32'h03E00008;
    localparam logic [31:0] I_BAD   = 32'hFC000000;

    logic                clk = 1'b0;
    logic                resetn;
    logic                flush;
    logic                in_valid;
    logic [1:0]          in_count;
    logic [1:0][31:0]    in_pc;
    logic [1:0][31:0]    in_inst;
    logic                in_ready;
    logic [1:0]          out_valid;
    logic [1:0][31:0]    out_pc;
    decoded_inst_t [1:0] out_inst_d;
    logic [1:0]          out_accept;
    logic [3:0]          q_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    inst_decode_queue #(
        .FETCH_WIDTH (2),
        .ISSUE_WIDTH (2),
        .DEPTH       (8),
        .PAIR_DSLOT  (1)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_count   (in_count),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst_d (out_inst_d),
        .out_accept (out_accept),
        .q_count    (q_count)
    );

    task automatic cyc(input logic v, input logic [1:0] n,
                       input logic [31:0] p0, input logic [31:0] i0,
                       input logic [31:0] p1, input logic [31:0] i1,
                       input logic [1:0] acc, input logic fl);
        in_valid   = v;
        in_count   = n;
        in_pc[0]   = p0;
        in_inst[0] = i0;
        in_pc[1]   = p1;
        in_inst[1] = i1;
        out_accept = acc;
        flush      = fl;
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_count   = 2'd1;
        out_accept = 2'd0;
        flush      = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        total++;
        if (q_count !== 4'd0) begin
            bad++; $display("FAIL reset_count got=%0d want=0", q_count);
        end
        total++;
        if (out_valid !== 2'b00) begin
            bad++; $display("FAIL reset_valid got=%b want=00", out_valid);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", in_ready);
        end
    endtask

    task automatic test_basic();
        cyc(1, 2, 32'hBFC00000, I_ADDIU, 32'hBFC00004, I_ADDU, 0, 0);
        total++;
        if (out_valid !== 2'b11) begin
            bad++; $display("FAIL basic_valid got=%b want=11", out_valid);
        end
        total++;
        if (out_pc[0] !== 32'hBFC00000 || out_pc[1] !== 32'hBFC00004) begin
            bad++; $display("FAIL basic_pc got=%h,%h want=bfc00000,bfc00004", out_pc[0], out_pc[1]);
        end
        total++;
        if (out_inst_d[0].imm !== 32'h1 || out_inst_d[0].rd !== 5'd1
            || out_inst_d[0].inst_invalid !== 1'b0) begin
            bad++; $display("FAIL basic_dec0 imm=%h rd=%0d inv=%b want 1,1,0",
                            out_inst_d[0].imm, out_inst_d[0].rd, out_inst_d[0].inst_invalid);
        end
        total++;
        if (out_inst_d[1].rd !== 5'd3 || out_inst_d[1].br_op !== 3'd0) begin
            bad++; $display("FAIL basic_dec1 rd=%0d br=%0d want 3,0",
                            out_inst_d[1].rd, out_inst_d[1].br_op);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        total++;
        if (out_valid !== 2'b00 || q_count !== 4'd0) begin
            bad++; $display("FAIL basic_drain valid=%b cnt=%0d want 00,0", out_valid, q_count);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) begin
            cyc(1, 2, 32'h1000 + 32'(i * 8), I_ADDU, 32'h1004 + 32'(i * 8), I_ADDU, 0, 0);
            if (i == 2) begin
                total++;
                if (q_count !== 4'd6 || in_ready !== 1'b1) begin
                    bad++; $display("FAIL full_at6 cnt=%0d rdy=%b want 6,1", q_count, in_ready);
                end
            end
        end
        total++;
        if (q_count !== 4'd8 || in_ready !== 1'b0 || out_valid !== 2'b11) begin
            bad++; $display("FAIL full_at8 cnt=%0d rdy=%b v=%b want 8,0,11",
                            q_count, in_ready, out_valid);
        end
        cyc(1, 2, 32'h9000, I_ADDU, 32'h9004, I_ADDU, 0, 0);
        total++;
        if (q_count !== 4'd8 || out_pc[0] !== 32'h1000) begin
            bad++; $display("FAIL full_ignored cnt=%0d pc0=%h want 8,1000", q_count, out_pc[0]);
        end
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        total++;
        if (q_count !== 4'd7 || in_ready !== 1'b0 || out_pc[0] !== 32'h1004) begin
            bad++; $display("FAIL full_at7 cnt=%0d rdy=%b pc0=%h want 7,0,1004",
                            q_count, in_ready, out_pc[0]);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        total++;
        if (q_count !== 4'd5 || in_ready !== 1'b1 || out_pc[0] !== 32'h100C) begin
            bad++; $display("FAIL full_at5 cnt=%0d rdy=%b pc0=%h want 5,1,100c",
                            q_count, in_ready, out_pc[0]);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        total++;
        if (q_count !== 4'd0 || out_valid !== 2'b00) begin
            bad++; $display("FAIL full_drain cnt=%0d v=%b want 0,00", q_count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_pc;
        logic [31:0] nxt;
        exp_pc = 32'h2000;
        nxt    = 32'h2000;
        cyc(1, 2, nxt, I_ADDU, nxt + 4, I_ADDU, 0, 0);
        nxt = nxt + 8;
        for (int c = 0; c < 20; c++) begin
            total++;
            if (out_valid !== 2'b11 || q_count !== 4'd2
                || out_pc[0] !== exp_pc || out_pc[1] !== exp_pc + 4) begin
                bad++; $display("FAIL wrap_c%0d v=%b cnt=%0d pc=%h,%h want 11,2,%h,%h",
                                c, out_valid, q_count, out_pc[0], out_pc[1], exp_pc, exp_pc + 4);
            end
            cyc(1, 2, nxt, I_ADDU, nxt + 4, I_ADDU, 2, 0);
            nxt    = nxt + 8;
            exp_pc = exp_pc + 8;
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        total++;
        if (q_count !== 4'd0) begin
            bad++; $display("FAIL wrap_drain cnt=%0d want 0", q_count);
        end
    endtask

    task automatic test_pairing();
        cyc(1, 1, 32'h100, I_BEQ, 0, 0, 0, 0);
        total++;
        if (out_valid !== 2'b00 || q_count !== 4'd1) begin
            bad++; $display("FAIL pair_lone_br v=%b cnt=%0d want 00,1", out_valid, q_count);
        end
        cyc(1, 1, 32'h104, I_NOP, 0, 0, 0, 0);
        total++;
        if (out_valid !== 2'b11 || out_inst_d[0].br_op !== 3'd1) begin
            bad++; $display("FAIL pair_with_ds v=%b br=%0d want 11,1", out_valid, out_inst_d[0].br_op);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 2, 32'h200, I_ADDU, 32'h204, I_JR, 0, 0);
        total++;
        if (out_valid !== 2'b01) begin
            bad++; $display("FAIL pair_jr_last v=%b want 01", out_valid);
        end
        cyc(1, 1, 32'h208, I_NOP, 0, 0, 0, 0);
        total++;
        if (out_valid !== 2'b01 || q_count !== 4'd3) begin
            bad++; $display("FAIL pair_jr_window v=%b cnt=%0d want 01,3", out_valid, q_count);
        end
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        total++;
        if (out_valid !== 2'b11 || out_pc[0] !== 32'h204 || out_inst_d[0].br_op !== 3'd5) begin
            bad++; $display("FAIL pair_jr_go v=%b pc0=%h br=%0d want 11,204,5",
                            out_valid, out_pc[0], out_inst_d[0].br_op);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
        cyc(1, 1, 32'h300, I_BAD, 0, 0, 0, 0);
        total++;
        if (out_valid !== 2'b01 || out_inst_d[0].inst_invalid !== 1'b1) begin
            bad++; $display("FAIL invalid_inst v=%b inv=%b want 01,1",
                            out_valid, out_inst_d[0].inst_invalid);
        end
        cyc(0, 1, 0, 0, 0, 0, 1, 0);
        total++;
        if (q_count !== 4'd0) begin
            bad++; $display("FAIL pair_drain cnt=%0d want 0", q_count);
        end
    endtask

    task automatic test_flush();
        cyc(1, 2, 32'h3000, I_ADDU, 32'h3004, I_ADDU, 0, 0);
        cyc(1, 2, 32'h3008, I_ADDU, 32'h300C, I_ADDU, 0, 0);
        cyc(1, 1, 32'h3010, I_ADDU, 0, 0, 0, 0);
        total++;
        if (q_count !== 4'd5) begin
            bad++; $display("FAIL flush_setup cnt=%0d want 5", q_count);
        end
        cyc(1, 2, 32'h3014, I_ADDU, 32'h3018, I_ADDU, 1, 1);
        total++;
        if (q_count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            bad++; $display("FAIL flush_state cnt=%0d v=%b rdy=%b want 0,00,1",
                            q_count, out_valid, in_ready);
        end
        cyc(1, 2, 32'h400, I_ADDU, 32'h404, I_ADDIU, 0, 0);
        total++;
        if (out_valid !== 2'b11 || out_pc[0] !== 32'h400 || out_pc[1] !== 32'h404) begin
            bad++; $display("FAIL flush_after v=%b pc=%h,%h want 11,400,404",
                            out_valid, out_pc[0], out_pc[1]);
        end
        cyc(0, 1, 0, 0, 0, 0, 2, 0);
    endtask

    task automatic test_reset_mid();
        cyc(1, 2, 32'h500, I_ADDU, 32'h504, I_ADDU, 0, 0);
        cyc(1, 1, 32'h508, I_ADDU, 0, 0, 0, 0);
        total++;
        if (q_count !== 4'd3) begin
            bad++; $display("FAIL rstmid_setup cnt=%0d want 3", q_count);
        end
        resetn = 1'b0;
        cyc(1, 2, 32'h50C, I_ADDU, 32'h510, I_ADDU, 1, 0);
        resetn = 1'b1;
        total++;
        if (q_count !== 4'd0 || out_valid !== 2'b00 || in_ready !== 1'b1) begin
            bad++; $display("FAIL rstmid_state cnt=%0d v=%b rdy=%b want 0,00,1",
                            q_count, out_valid, in_ready);
        end
        cyc(1, 1, 32'h600, I_ADDIU, 0, 0, 0, 0);
        total++;
        if (out_valid !== 2'b01 || out_pc[0] !== 32'h600) begin
            bad++; $display("FAIL rstmid_after v=%b pc0=%h want 01,600", out_valid, out_pc[0]);
        end
    endtask

    initial begin
        resetn     = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        in_count   = 2'd1;
        in_pc      = '0;
        in_inst    = '0;
        out_accept = 2'd0;
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_pairing();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
